// File: rtl/ram2_sram_responder.sv
// On-chip stand-in for the external RAM2 SRAM. It answers the RAM2 pin protocol,
// flags protocol abuse and out-of-range addresses, and counts completed accesses.
module ram2_sram_responder #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int READ_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Ram2Addr,
    inout  wire  [DATA_W-1:0] Ram2Data,
    input  logic              Ram2OE,
    input  logic              Ram2WE,
    input  logic              Ram2EN,
    output logic              bus_driving,
    output logic              proto_error,
    output logic              addr_oob,
    output logic [15:0]       read_count,
    output logic [15:0]       write_count
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WR_ACTIVE} state_t;
    typedef enum logic [1:0] {DEC_OFF, DEC_RD, DEC_WR, DEC_BAD} dec_t;

    // Value of lat_cnt at which a held read moves to the drive phase.
    localparam logic [2:0] LAT_LAST = (READ_LAT > 1) ? 3'(READ_LAT - 1) : 3'd0;

    state_t              state, state_n;
    dec_t                dec;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic [DATA_W-1:0]   data_q, data_n;
    logic [2:0]          lat_q, lat_n;
    logic                mem_we;
    logic                enter_drive;
    logic                addr_hi;
    logic                same_addr;
    logic [DATA_W-1:0]   rd_data_q;
    logic [DATA_W-1:0]   mem [2**DEPTH_LOG2];

    always_comb begin
        dec = DEC_OFF;
        if (!Ram2EN) begin
            case ({Ram2OE, Ram2WE})
                2'b01:   dec = DEC_RD;
                2'b10:   dec = DEC_WR;
                2'b00:   dec = DEC_BAD;
                default: dec = DEC_OFF;
            endcase
        end
    end

    assign addr_hi   = |Ram2Addr[ADDR_W-1:DEPTH_LOG2];
    assign same_addr = (Ram2Addr == addr_q);

    always_comb begin
        state_n = state;
        addr_n  = addr_q;
        data_n  = data_q;
        lat_n   = lat_q;
        mem_we  = 1'b0;
        case (state)
            IDLE: begin
                if (dec == DEC_RD) begin
                    addr_n  = Ram2Addr;
                    lat_n   = 3'd0;
                    state_n = (READ_LAT == 0) ? RD_DRIVE : RD_WAIT;
                end else if (dec == DEC_WR) begin
                    addr_n  = Ram2Addr;
                    data_n  = Ram2Data;
                    state_n = WR_ACTIVE;
                end
            end
            RD_WAIT: begin
                if (dec == DEC_RD && same_addr) begin
                    if (lat_q >= LAT_LAST) state_n = RD_DRIVE;
                    else                   lat_n   = lat_q + 3'd1;
                end else if (dec == DEC_RD) begin
                    addr_n = Ram2Addr;
                    lat_n  = 3'd0;
                end else begin
                    state_n = IDLE;
                end
            end
            RD_DRIVE: begin
                if (dec == DEC_RD && !same_addr) begin
                    addr_n  = Ram2Addr;
                    lat_n   = 3'd0;
                    state_n = RD_WAIT;
                end else if (dec != DEC_RD) begin
                    state_n = IDLE;
                end
            end
            WR_ACTIVE: begin
                if (Ram2EN) begin
                    state_n = IDLE;
                end else if (!Ram2WE) begin
                    addr_n = Ram2Addr;
                    data_n = Ram2Data;
                end else begin
                    mem_we  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // A conflicting OE/WE sample overrides everything, including a pending commit.
        if (dec == DEC_BAD) begin
            state_n = IDLE;
            mem_we  = 1'b0;
        end
    end

    assign enter_drive = (state_n == RD_DRIVE) && (state != RD_DRIVE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            lat_q       <= '0;
            proto_error <= 1'b0;
            addr_oob    <= 1'b0;
            read_count  <= '0;
            write_count <= '0;
        end else begin
            state  <= state_n;
            addr_q <= addr_n;
            data_q <= data_n;
            lat_q  <= lat_n;
            if (dec == DEC_BAD) proto_error <= 1'b1;
            if ((dec == DEC_RD || dec == DEC_WR) && addr_hi) addr_oob <= 1'b1;
            if (enter_drive) read_count  <= read_count + 16'd1;
            if (mem_we)      write_count <= write_count + 16'd1;
        end
    end

    // NOTE: the array and read register carry no reset so they map onto block RAM;
    // only the write strobe is qualified by rst so a pending write is dropped.
    always_ff @(posedge clk) begin
        if (rst && mem_we) mem[addr_q[DEPTH_LOG2-1:0]] <= data_q;
        if (enter_drive)   rd_data_q <= mem[addr_n[DEPTH_LOG2-1:0]];
    end

    assign bus_driving = (state == RD_DRIVE);
    assign Ram2Data    = bus_driving ? rd_data_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram2_sram_responder.sv
// Directed bench for ram2_sram_responder: three instances at READ_LAT 0, 1 and 3
// share the control pins, each with its own data bus.
module tb_ram2_sram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] addr = '0;
    logic        oe = 1'b1, we = 1'b1, en = 1'b1;
    logic        tb_oe = 1'b0;
    logic [15:0] tb_wdata = '0;
    wire  [15:0] d0, d1, d3;
    logic        drv0, drv1, drv3;
    logic        pe0, pe1, pe3, oob0, oob1, oob3;
    logic [15:0] rc0, rc1, rc3, wc0, wc1, wc3;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    assign d0 = tb_oe ? tb_wdata : 16'hzzzz;
    assign d1 = tb_oe ? tb_wdata : 16'hzzzz;
    assign d3 = tb_oe ? tb_wdata : 16'hzzzz;

    ram2_sram_responder #(.READ_LAT(0)) u0 (
        .clk(clk), .rst(rst), .Ram2Addr(addr), .Ram2Data(d0), .Ram2OE(oe), .Ram2WE(we),
        .Ram2EN(en), .bus_driving(drv0), .proto_error(pe0), .addr_oob(oob0),
        .read_count(rc0), .write_count(wc0));
    ram2_sram_responder #(.READ_LAT(1)) u1 (
        .clk(clk), .rst(rst), .Ram2Addr(addr), .Ram2Data(d1), .Ram2OE(oe), .Ram2WE(we),
        .Ram2EN(en), .bus_driving(drv1), .proto_error(pe1), .addr_oob(oob1),
        .read_count(rc1), .write_count(wc1));
    ram2_sram_responder #(.READ_LAT(3)) u3 (
        .clk(clk), .rst(rst), .Ram2Addr(addr), .Ram2Data(d3), .Ram2OE(oe), .Ram2WE(we),
        .Ram2EN(en), .bus_driving(drv3), .proto_error(pe3), .addr_oob(oob3),
        .read_count(rc3), .write_count(wc3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pins_idle();
        en = 1'b1; oe = 1'b1; we = 1'b1; tb_oe = 1'b0;
    endtask

    task automatic pins_read(input logic [17:0] a);
        addr = a; en = 1'b0; oe = 1'b0; we = 1'b1; tb_oe = 1'b0;
    endtask

    // WE low for two cycles, then released with EN still low to commit.
    task automatic write_word(input logic [17:0] a, input logic [15:0] d);
        addr = a; tb_wdata = d; tb_oe = 1'b1; en = 1'b0; oe = 1'b1; we = 1'b0;
        tick();
        tick();
        we = 1'b1; tb_oe = 1'b0;
        tick();
        pins_idle();
        tick();
    endtask

    task automatic test_reset();
        pins_idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_tests++;
        if ({drv0, drv1, drv3} !== 3'b000) begin
            n_fail++; $display("FAIL reset_drive: got %b expected 000", {drv0, drv1, drv3});
        end
        n_tests++;
        if ({pe1, oob1} !== 2'b00) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00", {pe1, oob1});
        end
        n_tests++;
        if (rc1 !== 16'd0 || wc1 !== 16'd0) begin
            n_fail++; $display("FAIL reset_counts: got rc=%0d wc=%0d expected 0 0", rc1, wc1);
        end
        tick();
    endtask

    task automatic test_write_read_latency();
        logic [2:0] got, exp;
        write_word(18'h00005, 16'h1234);
        pins_read(18'h00005);
        for (int k = 1; k <= 5; k++) begin
            tick();
            got = {drv3, drv1, drv0};
            exp = {(k >= 4), (k >= 2), (k >= 1)};
            n_tests++;
            if (got !== exp) begin
                n_fail++; $display("FAIL latency_cycle%0d: got %b expected %b", k, got, exp);
            end
        end
        n_tests++;
        if (d0 !== 16'h1234 || d1 !== 16'h1234 || d3 !== 16'h1234) begin
            n_fail++; $display("FAIL read_data: got %h %h %h expected 1234", d0, d1, d3);
        end
        pins_idle();
        tick();
        n_tests++;
        if (drv1 !== 1'b0) begin
            n_fail++; $display("FAIL release_on_en: got %b expected 0", drv1);
        end
        n_tests++;
        if (wc1 !== 16'd1 || rc1 !== 16'd1 || rc3 !== 16'd1) begin
            n_fail++; $display("FAIL counts_wr_rd: got wc=%0d rc=%0d rc3=%0d expected 1 1 1", wc1, rc1, rc3);
        end
    endtask

    task automatic test_bus_conflict();
        pins_read(18'h00005);
        tick();
        tick();
        we = 1'b0;
        tick();
        n_tests++;
        if (pe1 !== 1'b1 || drv1 !== 1'b0 || drv0 !== 1'b0) begin
            n_fail++; $display("FAIL conflict: got pe=%b drv1=%b drv0=%b expected 1 0 0", pe1, drv1, drv0);
        end
        pins_idle();
        tick();
        pins_read(18'h00005);
        tick();
        tick();
        n_tests++;
        if (drv1 !== 1'b1 || d1 !== 16'h1234) begin
            n_fail++; $display("FAIL conflict_readback: got drv=%b data=%h expected 1 1234", drv1, d1);
        end
        pins_idle();
        tick();
    endtask

    task automatic test_write_abort();
        addr = 18'h00005; tb_wdata = 16'hBEEF; tb_oe = 1'b1; en = 1'b0; oe = 1'b1; we = 1'b0;
        tick();
        tick();
        en = 1'b1;
        tick();
        pins_idle();
        tick();
        n_tests++;
        if (wc1 !== 16'd1) begin
            n_fail++; $display("FAIL abort_wcount: got %0d expected 1", wc1);
        end
        pins_read(18'h00005);
        tick();
        tick();
        n_tests++;
        if (drv1 !== 1'b1 || d1 !== 16'h1234) begin
            n_fail++; $display("FAIL abort_readback: got drv=%b data=%h expected 1 1234", drv1, d1);
        end
        pins_idle();
        tick();
    endtask

    task automatic test_alias();
        n_tests++;
        if (oob1 !== 1'b0) begin
            n_fail++; $display("FAIL oob_before: got %b expected 0", oob1);
        end
        addr = 18'h00400; tb_wdata = 16'hA5A5; tb_oe = 1'b1; en = 1'b0; oe = 1'b1; we = 1'b0;
        tick();
        n_tests++;
        if (oob1 !== 1'b1) begin
            n_fail++; $display("FAIL oob_set: got %b expected 1", oob1);
        end
        tick();
        we = 1'b1; tb_oe = 1'b0;
        tick();
        pins_idle();
        tick();
        pins_read(18'h00000);
        tick();
        tick();
        n_tests++;
        if (drv1 !== 1'b1 || d1 !== 16'hA5A5) begin
            n_fail++; $display("FAIL alias_read: got drv=%b data=%h expected 1 a5a5", drv1, d1);
        end
        pins_idle();
        tick();
        n_tests++;
        if (wc1 !== 16'd2 || rc1 !== 16'd5) begin
            n_fail++; $display("FAIL alias_counts: got wc=%0d rc=%0d expected 2 5", wc1, rc1);
        end
    endtask

    task automatic test_back_to_back();
        addr = 18'h00009; tb_wdata = 16'h7777; tb_oe = 1'b1; en = 1'b0; oe = 1'b1; we = 1'b0;
        tick();
        tick();
        pins_read(18'h00009);
        tick();
        n_tests++;
        if (drv0 !== 1'b0 || wc1 !== 16'd3) begin
            n_fail++; $display("FAIL b2b_commit: got drv0=%b wc=%0d expected 0 3", drv0, wc1);
        end
        tick();
        n_tests++;
        if (drv0 !== 1'b1 || d0 !== 16'h7777 || drv1 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_lat0: got drv0=%b data=%h drv1=%b expected 1 7777 0", drv0, d0, drv1);
        end
        tick();
        n_tests++;
        if (drv1 !== 1'b1 || d1 !== 16'h7777) begin
            n_fail++; $display("FAIL b2b_lat1: got drv=%b data=%h expected 1 7777", drv1, d1);
        end
        pins_idle();
        tick();
    endtask

    task automatic test_addr_change();
        pins_read(18'h00005);
        tick();
        tick();
        addr = 18'h00009;
        tick();
        n_tests++;
        if (drv1 !== 1'b0) begin
            n_fail++; $display("FAIL addr_change_release: got %b expected 0", drv1);
        end
        tick();
        n_tests++;
        if (drv1 !== 1'b1 || d1 !== 16'h7777 || rc1 !== 16'd8) begin
            n_fail++; $display("FAIL addr_change_read: got drv=%b data=%h rc=%0d expected 1 7777 8", drv1, d1, rc1);
        end
    endtask

    task automatic test_reset_mid_read();
        rst = 1'b0;
        tick();
        n_tests++;
        if (drv1 !== 1'b0 || drv0 !== 1'b0) begin
            n_fail++; $display("FAIL midreset_release: got %b %b expected 0 0", drv1, drv0);
        end
        n_tests++;
        if (rc1 !== 16'd0 || wc1 !== 16'd0 || pe1 !== 1'b0 || oob1 !== 1'b0) begin
            n_fail++; $display("FAIL midreset_state: got rc=%0d wc=%0d pe=%b oob=%b expected 0 0 0 0",
                               rc1, wc1, pe1, oob1);
        end
        rst = 1'b1;
        pins_idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read_latency();
        test_bus_conflict();
        test_write_abort();
        test_alias();
        test_back_to_back();
        test_addr_change();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
